aes_serial_sequencer: RTL

- Sequences one encrypt and one decrypt AES core, both with the serial cs/miso/mosi/finished interface, behind a single parallel request/response port.
- Accepts a 128-bit block, a 128-bit key and a mode bit, then serially loads the selected core and waits for its finished flag.
- Shifts the 128-bit result back and presents it in parallel.
- Serialises access: one operation in flight; the unselected core is held idle.

---
 rtl/aes_serial_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/aes_serial_sequencer.sv
`default_nettype none
// ============================================================================
// aes_serial_sequencer : one-at-a-time parallel front end for a serial encrypt
// core and a serial decrypt core (load frame, wait finished, read result).
// Revision : 1.0
// ============================================================================
module aes_serial_sequencer #(
   parameter int DATA_W  = 128,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_mode,
   input  logic [DATA_W-1:0] req_data,
   input  logic [DATA_W-1:0] req_key,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_mode,
   output logic              resp_err,
   output logic              enc_cs,
   output logic              enc_miso,
   input  logic              enc_mosi,
   input  logic              enc_finished,
   output logic              dec_cs,
   output logic              dec_miso,
   input  logic              dec_mosi,
   input  logic              dec_finished,
   output logic              busy
);

   localparam int               IDX_W          = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] C_LOAD_LAST    = CNT_W'(2*DATA_W-1);
   localparam logic [CNT_W-1:0] C_READ_LAST    = CNT_W'(DATA_W-1);
   localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT-1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LOAD_SETUP = 3'd1,
      S_LOAD_SHIFT = 3'd2,
      S_COMPUTE    = 3'd3,
      S_READ_SETUP = 3'd4,
      S_READ_SHIFT = 3'd5,
      S_RESP       = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic [2*DATA_W-1:0]   sreg_q, sreg_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_W-1:0]     result_q, result_d;
   logic                  mode_q, mode_d;
   logic                  err_q, err_d;
   logic                  w_sel_cs;
   logic                  w_sel_miso;
   logic                  w_fin;
   logic                  w_mosi;
   logic [IDX_W-1:0]      w_idx;

   // Only the selected core's handshake is observed; the other is ignored.
   assign w_fin  = mode_q ? dec_finished : enc_finished;
   assign w_mosi = mode_q ? dec_mosi     : enc_mosi;
   assign w_idx  = cnt_q[IDX_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         sreg_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         mode_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sreg_q   <= sreg_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         mode_q   <= mode_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sreg_d     = sreg_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      mode_d     = mode_q;
      err_d      = err_q;
      w_sel_cs   = 1'b0;
      w_sel_miso = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               sreg_d  = {req_key, req_data};
               mode_d  = req_mode;
               cnt_d   = '0;
               state_d = S_LOAD_SETUP;
            end
         end
         S_LOAD_SETUP: begin
            w_sel_cs = 1'b1;
            cnt_d    = '0;
            state_d  = S_LOAD_SHIFT;
         end
         S_LOAD_SHIFT: begin
            w_sel_cs   = 1'b1;
            w_sel_miso = sreg_q[0];
            sreg_d     = sreg_q >> 1;
            if (cnt_q == C_LOAD_LAST) begin
               cnt_d   = '0;
               state_d = S_COMPUTE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_COMPUTE: begin
            // A finished flag on the final allowed cycle still wins over the abort.
            if (w_fin) begin
               cnt_d   = '0;
               state_d = S_READ_SETUP;
            end else if (cnt_q == C_TIMEOUT_LAST) begin
               result_d = '0;
               err_d    = 1'b1;
               cnt_d    = '0;
               state_d  = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_READ_SETUP: begin
            w_sel_cs = 1'b1;
            cnt_d    = '0;
            state_d  = S_READ_SHIFT;
         end
         S_READ_SHIFT: begin
            w_sel_cs        = 1'b1;
            result_d[w_idx] = w_mosi;
            if (cnt_q == C_READ_LAST) begin
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_data  = result_q;
   assign resp_mode  = mode_q;
   assign resp_err   = err_q;
   assign enc_cs     = w_sel_cs   & ~mode_q;
   assign enc_miso   = w_sel_miso & ~mode_q;
   assign dec_cs     = w_sel_cs   &  mode_q;
   assign dec_miso   = w_sel_miso &  mode_q;

endmodule
`default_nettype wire
